// File: rtl/avl_noc_shim.sv
// rtl/avl_noc_shim.sv - Avalon-ST to NoC skid FIFO shim with ready-latency-1 output stage.
// Optional framing checker enabled by AVL_NOC_SHIM_PKTCHK_EN.
module avl_noc_shim #(
  parameter int WIDTH_PKT = 546,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_PKT-1:0] avl_data_in,
  input  logic [3:0]           avl_valid_in,
  input  logic [3:0]           avl_sop_in,
  input  logic [3:0]           avl_eop_in,
  output logic                 avl_ready_out,
  output logic [WIDTH_PKT-1:0] noc_data_out,
  output logic [3:0]           noc_valid_out,
  output logic [3:0]           noc_sop_out,
  output logic [3:0]           noc_eop_out,
  input  logic                 noc_ready_in,
  output logic                 err_out
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH_PKT-1:0] mem_data  [DEPTH];
  logic [3:0]           mem_valid [DEPTH];
  logic [3:0]           mem_sop   [DEPTH];
  logic [3:0]           mem_eop   [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;

  // Ready has no lookahead on a same-cycle pop: a full FIFO stalls the source one cycle.
  assign avl_ready_out = (count != FULL_CNT);
  assign push          = avl_ready_out & (|avl_valid_in);
  assign pop           = noc_ready_in & (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= avl_data_in;
      mem_valid[wr_ptr] <= avl_valid_in;
      mem_sop[wr_ptr]   <= avl_sop_in;
      mem_eop[wr_ptr]   <= avl_eop_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // noc_ready_in sampled at this edge is the previous cycle's ready, giving ready-latency 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      noc_data_out  <= '0;
      noc_valid_out <= '0;
      noc_sop_out   <= '0;
      noc_eop_out   <= '0;
    end else if (pop) begin
      noc_data_out  <= mem_data[rd_ptr];
      noc_valid_out <= mem_valid[rd_ptr];
      noc_sop_out   <= mem_sop[rd_ptr];
      noc_eop_out   <= mem_eop[rd_ptr];
    end else begin
      noc_valid_out <= '0;
      noc_sop_out   <= '0;
      noc_eop_out   <= '0;
    end
  end

`ifdef AVL_NOC_SHIM_PKTCHK_EN
  typedef enum logic {CHK_IDLE, CHK_IN_PKT} chk_state_t;

  chk_state_t chk_state;
  chk_state_t chk_state_nxt;
  logic       err_q;
  logic       err_nxt;
  logic       sop_any;
  logic       eop_any;

  assign sop_any = |avl_sop_in;
  assign eop_any = |avl_eop_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_state <= CHK_IDLE;
      err_q     <= 1'b0;
    end else begin
      chk_state <= chk_state_nxt;
      err_q     <= err_nxt;
    end
  end

  // Only accepted beats advance the checker; the error flag is sticky until reset.
  always_comb begin
    chk_state_nxt = chk_state;
    err_nxt       = err_q;
    if (push) begin
      case (chk_state)
        CHK_IDLE: begin
          if (!sop_any)      err_nxt       = 1'b1;
          else if (!eop_any) chk_state_nxt = CHK_IN_PKT;
        end
        CHK_IN_PKT: begin
          if (sop_any) err_nxt       = 1'b1;
          if (eop_any) chk_state_nxt = CHK_IDLE;
        end
        default: chk_state_nxt = CHK_IDLE;
      endcase
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_avl_noc_shim.sv
// tb/tb_avl_noc_shim.sv - Directed self-checking bench for avl_noc_shim.
module tb_avl_noc_shim;

  localparam int W = 546;
`ifdef AVL_NOC_SHIM_PKTCHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] avl_data_in;
  logic [3:0]   avl_valid_in;
  logic [3:0]   avl_sop_in;
  logic [3:0]   avl_eop_in;
  logic         avl_ready_out;
  logic [W-1:0] noc_data_out;
  logic [3:0]   noc_valid_out;
  logic [3:0]   noc_sop_out;
  logic [3:0]   noc_eop_out;
  logic         noc_ready_in;
  logic         err_out;

  int errors = 0;
  int checks = 0;

  logic [63:0] bd [5];
  logic [3:0]  bv [5];
  logic [3:0]  bs [5];
  logic [3:0]  be [5];

  always #5 clk = ~clk;

  avl_noc_shim #(.WIDTH_PKT(W), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .avl_data_in  (avl_data_in),
    .avl_valid_in (avl_valid_in),
    .avl_sop_in   (avl_sop_in),
    .avl_eop_in   (avl_eop_in),
    .avl_ready_out(avl_ready_out),
    .noc_data_out (noc_data_out),
    .noc_valid_out(noc_valid_out),
    .noc_sop_out  (noc_sop_out),
    .noc_eop_out  (noc_eop_out),
    .noc_ready_in (noc_ready_in),
    .err_out      (err_out)
  );

  function automatic logic [W-1:0] mk(input logic [63:0] d);
    return {d[7:0], 474'b0, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                     input logic [63:0] d);
    avl_valid_in = v;
    avl_sop_in   = s;
    avl_eop_in   = e;
    avl_data_in  = mk(d);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] v, input logic [3:0] s,
                         input logic [3:0] e, input logic [63:0] d);
    chk({tag, "_lanes"}, {52'b0, noc_valid_out, noc_sop_out, noc_eop_out}, {52'b0, v, s, e});
    if (v != 4'h0) chkd({tag, "_data"}, noc_data_out, mk(d));
  endtask

  initial begin
    rst          = 1'b1;
    noc_ready_in = 1'b0;
    put(4'h0, 4'h0, 4'h0, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", {63'b0, avl_ready_out}, 64'h1);
    chk_out("rst_out", 4'h0, 4'h0, 4'h0, 64'h0);
    chkd("rst_data", noc_data_out, '0);
    chk("rst_err", {63'b0, err_out}, 64'h0);

    // 3-beat packet streamed with ready held high
    noc_ready_in = 1'b1;
    put(4'hF, 4'h1, 4'h0, 64'hA1);
    tick();
    chk_out("pkt_lat", 4'h0, 4'h0, 4'h0, 64'h0);
    put(4'hF, 4'h0, 4'h0, 64'hA2);
    tick();
    chk_out("pkt_b0", 4'hF, 4'h1, 4'h0, 64'hA1);
    put(4'hF, 4'h0, 4'h8, 64'hA3);
    tick();
    chk_out("pkt_b1", 4'hF, 4'h0, 4'h0, 64'hA2);
    put(4'h0, 4'h0, 4'h0, 64'h0);
    tick();
    chk_out("pkt_b2", 4'hF, 4'h0, 4'h8, 64'hA3);
    tick();
    chk_out("pkt_empty", 4'h0, 4'h0, 4'h0, 64'h0);
    chkd("pkt_hold", noc_data_out, mk(64'hA3));

    // Fill with ready low, then drain and accept the stalled 5th beat
    bd[0] = 64'hB1; bv[0] = 4'h1; bs[0] = 4'h1; be[0] = 4'h0;
    bd[1] = 64'hB2; bv[1] = 4'h3; bs[1] = 4'h0; be[1] = 4'h0;
    bd[2] = 64'hB3; bv[2] = 4'h7; bs[2] = 4'h0; be[2] = 4'h0;
    bd[3] = 64'hB4; bv[3] = 4'hF; bs[3] = 4'h0; be[3] = 4'h0;
    bd[4] = 64'hB5; bv[4] = 4'h5; bs[4] = 4'h0; be[4] = 4'h4;
    noc_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(bv[i], bs[i], be[i], bd[i]);
      tick();
      chk($sformatf("full_ready%0d", i), {63'b0, avl_ready_out}, (i == 3) ? 64'h0 : 64'h1);
      chk_out($sformatf("full_stall%0d", i), 4'h0, 4'h0, 4'h0, 64'h0);
    end
    put(bv[4], bs[4], be[4], bd[4]);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("full_hold%0d", i), {63'b0, avl_ready_out}, 64'h0);
      chk_out($sformatf("full_hold_out%0d", i), 4'h0, 4'h0, 4'h0, 64'h0);
    end
    noc_ready_in = 1'b1;
    tick();
    chk_out("drain0", bv[0], bs[0], be[0], bd[0]);
    chk("drain_ready", {63'b0, avl_ready_out}, 64'h1);
    tick();
    chk_out("drain1", bv[1], bs[1], be[1], bd[1]);
    put(4'h0, 4'h0, 4'h0, 64'h0);
    for (int i = 2; i < 5; i++) begin
      tick();
      chk_out($sformatf("drain%0d", i), bv[i], bs[i], be[i], bd[i]);
    end
    tick();
    chk_out("drain_empty", 4'h0, 4'h0, 4'h0, 64'h0);

    // Ready toggling with two entries queued
    noc_ready_in = 1'b0;
    put(4'hF, 4'h2, 4'h0, 64'hC1);
    tick();
    put(4'hF, 4'h0, 4'h2, 64'hC2);
    tick();
    put(4'h0, 4'h0, 4'h0, 64'h0);
    noc_ready_in = 1'b1;
    tick();
    chk_out("tog_r1", 4'hF, 4'h2, 4'h0, 64'hC1);
    noc_ready_in = 1'b0;
    tick();
    chk_out("tog_r0", 4'h0, 4'h0, 4'h0, 64'h0);
    noc_ready_in = 1'b1;
    tick();
    chk_out("tog_r1b", 4'hF, 4'h0, 4'h2, 64'hC2);
    noc_ready_in = 1'b0;
    tick();
    chk_out("tog_r0b", 4'h0, 4'h0, 4'h0, 64'h0);
    noc_ready_in = 1'b1;
    tick();
    chk_out("tog_nodup", 4'h0, 4'h0, 4'h0, 64'h0);
    chk("tog_err", {63'b0, err_out}, 64'h0);

    // Reset mid-packet with three beats buffered
    noc_ready_in = 1'b0;
    put(4'hF, 4'h1, 4'h0, 64'hD1);
    tick();
    put(4'hF, 4'h0, 4'h0, 64'hD2);
    tick();
    put(4'hF, 4'h0, 4'h0, 64'hD3);
    tick();
    put(4'h0, 4'h0, 4'h0, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ready", {63'b0, avl_ready_out}, 64'h1);
    chk_out("mrst_out", 4'h0, 4'h0, 4'h0, 64'h0);
    chkd("mrst_data", noc_data_out, '0);
    noc_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("mrst_stale%0d", i), 4'h0, 4'h0, 4'h0, 64'h0);
    end
    put(4'h9, 4'h1, 4'h8, 64'hE1);
    tick();
    put(4'h0, 4'h0, 4'h0, 64'h0);
    tick();
    chk_out("mrst_first", 4'h9, 4'h1, 4'h8, 64'hE1);
    chk("mrst_err", {63'b0, err_out}, 64'h0);

    // Framing: sop, sop without eop, then another beat
    put(4'hF, 4'h1, 4'h0, 64'hF1);
    tick();
    chk("frm_sop1", {63'b0, err_out}, 64'h0);
    put(4'hF, 4'h1, 4'h0, 64'hF2);
    tick();
    chk("frm_sop2", {63'b0, err_out}, {63'b0, CHK_EN});
    put(4'hF, 4'h0, 4'h1, 64'hF3);
    tick();
    chk("frm_any", {63'b0, err_out}, {63'b0, CHK_EN});
    put(4'h0, 4'h0, 4'h0, 64'h0);
    tick();
    tick();
    chk("frm_sticky", {63'b0, err_out}, {63'b0, CHK_EN});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("frm_rst", {63'b0, err_out}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avl_noc_shim.md
AVL_NOC_SHIM -- requirements
Module: avl_noc_shim

Interface
REQ-001 SHALL have parameter WIDTH_PKT, default 546 (512+1+1+32), meaning the width of the packet data word with flit headers removed.
REQ-002 SHALL have parameter DEPTH, default 4, meaning skid FIFO entries; power of two, minimum 2.
REQ-003 SHALL use one clock; reset is synchronous and active-high. Ports: clk input 1, clock; rst input 1, synchronous active-high reset.
REQ-004 avl_data_in  input  WIDTH_PKT  Avalon-side packet word.
REQ-005 avl_valid_in  input  4  per-lane valid; a beat exists when any bit is 1.
REQ-006 avl_sop_in / avl_eop_in  input  4 each  per-lane start/end of packet.
REQ-007 avl_ready_out  output  1  zero-latency ready (inverse waitrequest).
REQ-008 noc_data_out  output  WIDTH_PKT  NoC-side packet word.
REQ-009 noc_valid_out / noc_sop_out / noc_eop_out  output  4 each  NoC-side qualifiers.
REQ-010 noc_ready_in  input  1  NoC ready, ready-latency 1.
REQ-011 err_out  output  1  sticky framing error flag.

Function
REQ-012 Avalon transfer SHALL occur in any cycle where avl_ready_out=1 and |avl_valid_in=1; data, valid, sop and eop are written to the FIFO tail at that edge.
REQ-013 Beats with avl_valid_in=0 SHALL NOT be stored.
REQ-014 avl_ready_out SHALL equal (count != DEPTH), with no lookahead on a same-cycle pop.
REQ-015 The FIFO SHALL use rd_ptr and wr_ptr of log2(DEPTH) bits that wrap modulo DEPTH, plus count of log2(DEPTH)+1 bits.
  - Count changes by +1 on push only, by -1 on pop only, and is unchanged on simultaneous push and pop.
REQ-016 Output stage registers: at each edge, if noc_ready_in=1 in the cycle before the edge and count!=0, the output registers SHALL load the head entry and pop it.
  - Otherwise noc_valid_out, noc_sop_out and noc_eop_out SHALL be driven 0.
  - In that case noc_data_out holds its last value.
REQ-017 noc_valid_out SHALL be nonzero only in a cycle following a cycle with noc_ready_in=1.
REQ-018 Minimum latency SHALL be 1 edge from the Avalon accept edge to noc_valid_out asserting, given noc_ready_in=1.
  - Packet order and lane bits SHALL be preserved exactly.
REQ-019 Full FIFO with noc_ready_in=0 SHALL hold all entries indefinitely without loss.
REQ-020 Empty FIFO with noc_ready_in=1 SHALL drive noc_valid_out=0.

Reset
REQ-021 On rst=1 at an edge, the block SHALL clear:
  - pointers and count to 0, so avl_ready_out=1 after the edge;
  - noc_valid_out, noc_sop_out and noc_eop_out to 0, and noc_data_out to 0;
  - err_out to 0 and the checker state to IDLE.
REQ-022 Reset asserted mid-packet SHALL discard all buffered beats; no partial packet SHALL be emitted after reset.

Configuration
REQ-023 With macro AVL_NOC_SHIM_PKTCHK_EN defined, the block SHALL include a framing checker FSM on accepted beats.
  - IDLE goes to IN_PKT on |sop & ~|eop.
  - IN_PKT goes to IDLE on |eop.
  - A beat with |sop & |eop in IDLE remains in IDLE.
  - err_out SHALL set to 1 and stay set until reset if either occurs: a non-sop beat is accepted in IDLE, or a sop beat is accepted in IN_PKT.
  - Data flow SHALL be unaffected by the checker.
REQ-024 Without AVL_NOC_SHIM_PKTCHK_EN, the checker SHALL be absent and err_out SHALL be tied 0.

Verification
REQ-025 Push a 3-beat packet (data 0xA1,0xA2,0xA3; sop on beat 0, eop on beat 2, valid 4'hF) with noc_ready_in=1 held high. Required: outputs appear in order, one edge after each accept, with lanes unchanged.
REQ-026 Hold noc_ready_in=0 and push 5 beats. Required: avl_ready_out=0 after the 4th accept; noc_valid_out stays 0; releasing ready drains 4 beats in order; the 5th beat is then accepted.
REQ-027 Toggle noc_ready_in 1,0,1,0 with FIFO count=2. Required: noc_valid_out is nonzero only in cycles following ready=1, and no beat is lost or duplicated.
REQ-028 Assert rst while count=3 mid-packet. Required: after the edge count=0, noc_valid_out=0 and avl_ready_out=1; no stale beat is ever emitted.
REQ-029 With AVL_NOC_SHIM_PKTCHK_EN defined, send sop, sop (without eop), then any beat. Required: err_out=1 after the second accept and remains 1 until rst. Without the macro, err_out=0 throughout.
